// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit (1), WIDTH data bits, stop bit (0).
// Latency: start bit on sout the cycle after an accepted load; frame lasts WIDTH+2 cycles.
// Backpressure: load_ready high only in IDLE and STOP (never in reset), so frames can run back to back.
module serial_frame_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             c,
    input  logic             r,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             sout_q, sout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             head_bit;
    logic [WIDTH-1:0] word_shifted;

    // Ready depends only on state and reset so upstream sees no combinational path from load_valid.
    assign load_ready = ~r & ((state_q == IDLE) | (state_q == STOP));
    assign accept     = load_valid & load_ready;

    // The bit to send next always sits at the head of the word register; shifting moves the following bit up.
    assign head_bit     = MSB_FIRST ? word_q[WIDTH-1] : word_q[0];
    assign word_shifted = MSB_FIRST ? {word_q[WIDTH-2:0], 1'b0} : {1'b0, word_q[WIDTH-1:1]};

    // Next-state logic; sout/busy/done are computed for the state being entered so they can be registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        sout_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    word_d  = data_in;
                    sout_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
                sout_d  = head_bit;
                word_d  = word_shifted;
                busy_d  = 1'b1;
            end
            DATA: begin
                busy_d = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    sout_d = head_bit;
                    word_d = word_shifted;
                end
            end
            STOP: begin
                if (accept) begin
                    // Back-to-back frame: the stop bit is followed directly by the next start bit.
                    state_d = START;
                    word_d  = data_in;
                    sout_d  = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    word_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                word_d  = '0;
            end
        endcase
    end

    // State, counter, word and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
